// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, the ofm_reader state encoding and a
// lane-select helper used wherever a packed OFM word is split into bytes.
package cnn_pkg;

   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int WORD_W = LANES * DATA_W;
   localparam int IDX_W  = $clog2(LANES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } ofm_rd_state_t;

   // Lane 0 occupies the least significant byte of the packed word.
   function automatic logic [DATA_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx);
      lane_sel = word[idx*DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/word_unpacker.sv
// Holds the word currently being streamed and walks its byte lanes,
// lane 0 first, advancing one lane per accepted handshake.
module word_unpacker
   import cnn_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_accept,
   output logic [DATA_W-1:0] o_byte,
   output logic              o_valid,
   output logic              o_last
);

   logic [WORD_W-1:0] r_cur;
   logic [IDX_W-1:0]  r_idx;
   logic              r_vld;

   // Current word, lane index and occupancy; a load always wins over a final-lane accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur <= '0;
         r_idx <= '0;
         r_vld <= 1'b0;
      end else if (i_load) begin
         r_cur <= i_word;
         r_idx <= '0;
         r_vld <= 1'b1;
      end else if (i_accept) begin
         r_idx <= r_idx + IDX_W'(1);
         if (r_idx == IDX_W'(LANES - 1)) begin
            r_vld <= 1'b0;
         end else begin
            r_vld <= r_vld;
         end
      end else begin
         r_vld <= r_vld;
      end
   end

   assign o_byte  = lane_sel(r_cur, r_idx);
   assign o_valid = r_vld;
   assign o_last  = (r_idx == IDX_W'(LANES - 1));

endmodule

// File: rtl/ofm_reader.sv
// Drains packed OFM words from memory and streams them out byte by byte.
// A one-word prefetch slot keeps the stream gapless across word boundaries;
// when the stream register is empty the returning read bypasses the slot.
module ofm_reader
   import cnn_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_cnt,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WORD_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   ofm_rd_state_t     r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_base, r_cnt, r_issued, r_words_done, r_rd_addr;
   logic              r_rd_en, r_pend, r_nxt_vld, r_busy, r_done;
   logic [WORD_W-1:0] r_nxt;

   logic              w_valid, w_last, w_accept, w_last_acc, w_cur_free;
   logic              w_in_run, w_load, w_issue, w_start_go, w_start_rd, w_final;
   logic [WORD_W-1:0] w_load_word;

   assign w_in_run    = (r_state == S_RUN);
   assign w_start_go  = (r_state == S_IDLE) & start;
   assign w_start_rd  = w_start_go & (word_cnt != ADDR_W'(0));
   assign w_accept    = w_valid & out_ready;
   assign w_last_acc  = w_accept & w_last;
   assign w_cur_free  = ~w_valid | w_last_acc;
   // r_pend marks rd_data as holding the word requested last cycle.
   assign w_load      = w_in_run & w_cur_free & (r_nxt_vld | r_pend);
   assign w_load_word = r_nxt_vld ? r_nxt : rd_data;
   // One read in flight at most, and only into a slot that will be free on arrival.
   assign w_issue     = w_in_run & (r_issued < r_cnt) & ~r_rd_en & ~r_pend
                        & (~r_nxt_vld | w_load);
   assign w_final     = w_last_acc & (r_words_done == (r_cnt - ADDR_W'(1)));

   // Next-state decode for the transfer FSM.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (word_cnt == ADDR_W'(0)) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_final) begin
               w_state_nxt = S_FINISH;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered status and read-request outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_pend    <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == S_RUN);
         r_done <= (w_state_nxt == S_FINISH);
         r_pend <= r_rd_en;
         if (w_start_rd) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= base_addr;
         end else if (w_issue) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_base + r_issued;
         end else begin
            r_rd_en   <= 1'b0;
         end
      end
   end

   // Transfer parameters plus issued-word and completed-word counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_base       <= '0;
         r_cnt        <= '0;
         r_issued     <= '0;
         r_words_done <= '0;
      end else if (w_start_go) begin
         r_base       <= base_addr;
         r_cnt        <= word_cnt;
         r_issued     <= w_start_rd ? ADDR_W'(1) : ADDR_W'(0);
         r_words_done <= '0;
      end else begin
         if (w_issue) begin
            r_issued <= r_issued + ADDR_W'(1);
         end else begin
            r_issued <= r_issued;
         end
         if (w_last_acc) begin
            r_words_done <= r_words_done + ADDR_W'(1);
         end else begin
            r_words_done <= r_words_done;
         end
      end
   end

   // Prefetch slot: captures returning data unless it goes straight to the stream register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nxt     <= '0;
         r_nxt_vld <= 1'b0;
      end else if (r_pend & ~(w_load & ~r_nxt_vld)) begin
         r_nxt     <= rd_data;
         r_nxt_vld <= 1'b1;
      end else if (w_load & r_nxt_vld) begin
         r_nxt_vld <= 1'b0;
      end else begin
         r_nxt_vld <= r_nxt_vld;
      end
   end

   word_unpacker u_unpack (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_word   (w_load_word),
      .i_accept (w_accept),
      .o_byte   (out_data),
      .o_valid  (w_valid),
      .o_last   (w_last)
   );

   assign out_valid = w_valid;
   assign rd_en     = r_rd_en;
   assign rd_addr   = r_rd_addr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_ofm_reader.sv
// Directed bench for ofm_reader. Cycle k is the value seen 1 ns after the
// k-th rising edge following the edge that samples start (that edge is 0,
// so "cycle 1" is observed just after it).
module tb_ofm_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = 8'd0;
   logic [7:0]  word_cnt = 8'd0;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:255];
   int          n_vec = 0;
   int          n_miss = 0;

   logic [7:0]  byte_q[$];
   logic [7:0]  hold_q[$];
   logic [7:0]  addr_q[$];
   int          rd_cyc_q[$];
   int          first_vld, done_cyc, last_hs, n_done;
   logic        busy_at_done, busy_c1;

   ofm_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .word_cnt  (word_cnt),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read OFM memory model.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Starts a transfer and records what the DUT does, cycle by cycle.
   task automatic run_xfer(input logic [7:0] b, input logic [7:0] c, input int stall_idx,
                           input int stall_len, input int inj_cyc, input int max_cyc);
      byte_q.delete(); hold_q.delete(); addr_q.delete(); rd_cyc_q.delete();
      first_vld = -1; done_cyc = -1; last_hs = -1; n_done = 0;
      busy_at_done = 1'bx; busy_c1 = 1'bx;
      base_addr = b; word_cnt = c; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         start = (cyc == inj_cyc);
         if (start) begin
            base_addr = 8'd100;
            word_cnt  = 8'd7;
         end
         if (out_valid && (byte_q.size() == stall_idx) && (hold_q.size() < stall_len)) begin
            out_ready = 1'b0;
            hold_q.push_back(out_data);
         end else begin
            out_ready = 1'b1;
         end
         if (cyc == 1) busy_c1 = busy;
         if (rd_en) begin
            addr_q.push_back(rd_addr);
            rd_cyc_q.push_back(cyc);
         end
         if (out_valid && first_vld < 0) first_vld = cyc;
         if (out_valid && out_ready) begin
            byte_q.push_back(out_data);
            last_hs = cyc;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               busy_at_done = busy;
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      n_vec++; if (rd_en !== 1'b0)     begin n_miss++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
      n_vec++; if (rd_addr !== 8'h00)  begin n_miss++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr); end
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (out_data !== 8'h00) begin n_miss++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      n_vec++; if (busy !== 1'b0)      begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0)      begin n_miss++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      logic [7:0] got;
      run_xfer(8'd5, 8'd2, -1, 0, 0, 40);
      n_vec++; if (busy_c1 !== 1'b1) begin n_miss++; $display("FAIL basic_busy_c1: got %b want 1", busy_c1); end
      n_vec++; if (rd_cyc_q.size() < 1 || rd_cyc_q[0] != 1) begin n_miss++; $display("FAIL basic_rd_cycle: got %0d reads, first at %0d want cycle 1", rd_cyc_q.size(), (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1); end
      n_vec++; if (addr_q.size() != 2 || addr_q[0] !== 8'd5 || addr_q[1] !== 8'd6) begin n_miss++; $display("FAIL basic_addrs: got %0d reads want 2 at 5,6", addr_q.size()); end
      n_vec++; if (first_vld != 3) begin n_miss++; $display("FAIL basic_latency: got %0d want 3", first_vld); end
      n_vec++; if (byte_q.size() != 8) begin n_miss++; $display("FAIL basic_count: got %0d want 8", byte_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
         n_vec++; if (got !== exp_b[i]) begin n_miss++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_b[i]); end
      end
      n_vec++; if (last_hs != 10) begin n_miss++; $display("FAIL basic_last_hs: got %0d want 10", last_hs); end
      n_vec++; if (done_cyc != 11) begin n_miss++; $display("FAIL basic_done_cycle: got %0d want 11", done_cyc); end
      n_vec++; if (busy_at_done !== 1'b0) begin n_miss++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
      n_vec++; if (n_done != 1) begin n_miss++; $display("FAIL basic_done_pulses: got %0d want 1", n_done); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      logic [7:0] got;
      run_xfer(8'd5, 8'd2, 2, 3, 0, 60);
      n_vec++; if (hold_q.size() != 3) begin n_miss++; $display("FAIL bp_stall_cycles: got %0d want 3", hold_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < hold_q.size()) ? hold_q[i] : 8'hxx;
         n_vec++; if (got !== 8'h33) begin n_miss++; $display("FAIL bp_hold%0d: got %h want 33", i, got); end
      end
      n_vec++; if (byte_q.size() != 8) begin n_miss++; $display("FAIL bp_count: got %0d want 8", byte_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
         n_vec++; if (got !== exp_b[i]) begin n_miss++; $display("FAIL bp_byte%0d: got %h want %h", i, got, exp_b[i]); end
      end
      n_vec++; if (addr_q.size() != 2) begin n_miss++; $display("FAIL bp_reads: got %0d want 2", addr_q.size()); end
      n_vec++; if (done_cyc != 14) begin n_miss++; $display("FAIL bp_done_cycle: got %0d want 14", done_cyc); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_b [12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                                 8'hC0, 8'hC1, 8'hC2, 8'hC3};
      logic [7:0] exp_a [3] = '{8'd254, 8'd255, 8'd0};
      logic [7:0] got;
      run_xfer(8'd254, 8'd3, -1, 0, 0, 50);
      n_vec++; if (addr_q.size() != 3) begin n_miss++; $display("FAIL wrap_reads: got %0d want 3", addr_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < addr_q.size()) ? addr_q[i] : 8'hxx;
         n_vec++; if (got !== exp_a[i]) begin n_miss++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, got, exp_a[i]); end
      end
      for (int i = 0; i < 12; i++) begin
         got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
         n_vec++; if (got !== exp_b[i]) begin n_miss++; $display("FAIL wrap_byte%0d: got %h want %h", i, got, exp_b[i]); end
      end
      n_vec++; if (done_cyc != 15) begin n_miss++; $display("FAIL wrap_done_cycle: got %0d want 15", done_cyc); end
   endtask

   task automatic test_zero();
      run_xfer(8'd5, 8'd0, -1, 0, 0, 20);
      n_vec++; if (done_cyc != 1) begin n_miss++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
      n_vec++; if (addr_q.size() != 0) begin n_miss++; $display("FAIL zero_reads: got %0d want 0", addr_q.size()); end
      n_vec++; if (first_vld != -1) begin n_miss++; $display("FAIL zero_valid: got valid at cycle %0d want never", first_vld); end
      n_vec++; if (n_done != 1) begin n_miss++; $display("FAIL zero_done_pulses: got %0d want 1", n_done); end
   endtask

   task automatic test_start_ignored();
      logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      logic [7:0] got;
      run_xfer(8'd5, 8'd2, -1, 0, 5, 40);
      n_vec++; if (byte_q.size() != 8) begin n_miss++; $display("FAIL busy_start_count: got %0d want 8", byte_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
         n_vec++; if (got !== exp_b[i]) begin n_miss++; $display("FAIL busy_start_byte%0d: got %h want %h", i, got, exp_b[i]); end
      end
      n_vec++; if (addr_q.size() != 2 || addr_q[0] !== 8'd5 || addr_q[1] !== 8'd6) begin n_miss++; $display("FAIL busy_start_addrs: got %0d reads want 2 at 5,6", addr_q.size()); end
      n_vec++; if (done_cyc != 11) begin n_miss++; $display("FAIL busy_start_done_cycle: got %0d want 11", done_cyc); end
      n_vec++; if (n_done != 1) begin n_miss++; $display("FAIL busy_start_done_pulses: got %0d want 1", n_done); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL busy_start_idle: got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] got;
      int acc = 0;
      base_addr = 8'd5; word_cnt = 8'd2; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         if (out_valid && out_ready) acc++;
         if (acc == 5) break;
         @(posedge clk); #1;
      end
      n_vec++; if (acc != 5) begin n_miss++; $display("FAIL rstmid_reach5: got %0d bytes want 5", acc); end
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b0)      begin n_miss++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0)      begin n_miss++; $display("FAIL rstmid_done: got %b want 0", done); end
      n_vec++; if (rd_en !== 1'b0)     begin n_miss++; $display("FAIL rstmid_rd_en: got %b want 0", rd_en); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL rstmid_no_done: got %b want 0", done); end
      run_xfer(8'd5, 8'd1, -1, 0, 0, 30);
      n_vec++; if (byte_q.size() != 4) begin n_miss++; $display("FAIL rstmid_count: got %0d want 4", byte_q.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
         n_vec++; if (got !== exp_b[i]) begin n_miss++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got, exp_b[i]); end
      end
      n_vec++; if (done_cyc != 7) begin n_miss++; $display("FAIL rstmid_done_cycle: got %0d want 7", done_cyc); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[5]   = 32'h44332211;
      mem[6]   = 32'h88776655;
      mem[254] = 32'hA3A2A1A0;
      mem[255] = 32'hB3B2B1B0;
      mem[0]   = 32'hC3C2C1C0;
      mem[100] = 32'hDEADBEEF;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero();
      test_start_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ofm_reader.md
# ofm_reader

Drains the output feature map after a PE pass. The PE packs four 8-bit MAC results per OFM word. This block reads packed words from the OFM memory, starting at a base address, and unpacks each word into a byte stream under a valid/ready handshake. It sits between the OFM memory read port and the downstream consumer (next-layer loader or host drain), and is the read-side counterpart of the PE's shift-register/OFM write path.

## Interface
- ADDR_W, 8, OFM word-address width
- DATA_W, 8, byte-lane width
- LANES, 4, bytes per OFM word

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  one-cycle request; samples base_addr and word_cnt
- base_addr  in  ADDR_W  first OFM word address
- word_cnt  in  ADDR_W  number of words to drain (0 allowed)
- rd_en  out  1  OFM read strobe
- rd_addr  out  ADDR_W  OFM read address
- rd_data  in  LANES×DATA_W  OFM read data, valid one cycle after rd_en (synchronous read)
- out_data  out  DATA_W  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the final byte is accepted

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE: start=1 latches base_addr and word_cnt and moves to RUN. If word_cnt=0, moves to FINISH with no reads.
- start is ignored while busy=1.
- Two word registers:
  - cur: word being streamed, with a 2-bit byte index idx.
  - nxt: prefetch slot with a valid flag.
- Read issue rule: assert rd_en for a cycle when all of these hold:
  - words issued < word_cnt
  - no read is in flight
  - nxt is empty, or nxt is transferring into cur in that same cycle
- rd_addr = base + words issued, modulo 2^ADDR_W (the address wraps from 255 to 0).
- rd_data is written into nxt in the cycle after rd_en.
- cur loads from nxt when cur is empty, or when the last byte of cur (idx=3) is accepted in that cycle. On load, idx is set to 0.
- Byte order: out_data = lane idx of cur; lane 0 (bits DATA_W-1:0) is emitted first.
- Each handshake increments idx. Once the byte at idx=3 is accepted, cur empties unless it reloads in the same cycle.
- RUN → FINISH when the last byte of the last word is accepted.
- FINISH: done=1 for one cycle, then the FSM returns to IDLE.
- Backpressure: while out_valid=1 and out_ready=0, out_data and idx hold and no data is lost.
- Backpressure does not block the prefetch into nxt.

## Timing
- Reset values: all outputs 0, state IDLE, both slots empty, counters 0.
- Reset applied mid-transfer aborts immediately, with no done pulse.
- Let cycle 0 be the start edge.
  - Cycle 1: rd_en=1, rd_addr=base, busy=1.
  - Cycle 2: rd_data captured into nxt.
  - Cycle 3: first out_valid=1 (start-to-first-byte latency 3).
- With out_ready held at 1, the stream runs at one byte per cycle with no bubbles across word boundaries. N words take 4N consecutive valid cycles.
- done asserts in the cycle after the last handshake. busy falls in that same cycle.
- word_cnt=0: done pulses in cycle 1 and rd_en is never asserted.
- out_valid is never combinationally dependent on out_ready.

## Structure
- Shared package cnn_pkg holds:
  - LANES and DATA_W constants, shared with the PE shift register and OFM memory
  - the ofm_reader state enum
- One sub-module, word_unpacker, is natural: it holds the cur register, idx, and lane select, and its inputs are load/word/accept.
- Prefetch control and the FSM stay in the top level.

## Test plan
- Basic drain: OFM[5]={0x11,0x22,0x33,0x44}, OFM[6]={0x55,0x66,0x77,0x88}; start with base=5, cnt=2, ready=1.
  - Expect bytes 11,22,33,44,55,66,77,88 on 8 consecutive cycles starting at cycle 3.
  - Expect done on the cycle after the last byte, and rd_addr sequence 5,6.
- Backpressure: same data; drop out_ready for 3 cycles while the byte 0x33 is presented.
  - Expect 0x33 held stable for those cycles.
  - Expect the full byte sequence unchanged, no duplicate or dropped bytes, and exactly 2 reads.
- Wrap: base=254, cnt=3.
  - Expect rd_addr sequence 254, 255, 0, and 12 bytes in lane order.
- Zero count: cnt=0.
  - Expect done in cycle 1, no rd_en, out_valid never 1.
- Start ignored while busy: pulse start again mid-transfer with different base/cnt.
  - Expect the original transfer to complete unchanged, with one done pulse.
- Reset mid-transfer: assert rst=0 after the 5th byte.
  - Expect out_valid, busy, done, and rd_en all 0 asynchronously.
  - After release, a new start with base=5, cnt=1 produces 11,22,33,44 correctly.
